load_store_unit: RTL

Initiator-side controller for the data memory port. It accepts one load or store from the execute stage through a valid/ready handshake and checks funct3 legality and alignment. It then drives the memory's combinational-read / clocked-write port for exactly one cycle and returns a registered, sign- or zero-extended result with fault status. It sits between the pipeline's memory stage and `memory`, and owns all RV32 width decoding so that `memory` only ever sees widths 000/001/010.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/load_store_unit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 width codes, controller
// states and the load-data extension helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_ACCESS,
        LSU_RESP
    } lsu_state_t;

    // raw is LSB-aligned memory data; returns the architectural register value
    function automatic logic [31:0] load_extend(input logic [2:0] funct3,
                                                input logic [31:0] raw);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic [31:0]        res;
        byte_s = raw[7:0];
        half_s = raw[15:0];
        case (funct3)
            F3_B:    res = {{24{byte_s[7]}}, byte_s};
            F3_H:    res = {{16{half_s[15]}}, half_s};
            F3_W:    res = raw;
            F3_BU:   res = {24'b0, raw[7:0]};
            F3_HU:   res = {16'b0, raw[15:0]};
            default: res = 32'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts one load/store, validates funct3 and
// alignment, drives a single memory access cycle and returns a held response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_load,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_fault,
    output logic            resp_misaligned,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [2:0]      mem_width,
    output logic            mem_read_en,
    output logic            mem_write_en,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_fault
);

    lsu_state_t      state;
    logic            load_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;

    logic            req_legal;
    logic            req_misaligned;

    always_comb begin
        req_legal = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: req_legal = 1'b1;
            F3_BU, F3_HU:     req_legal = req_load;
            default:          req_legal = 1'b0;
        endcase
        req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    assign req_ready = (state == LSU_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= LSU_IDLE;
            load_q          <= 1'b0;
            funct3_q        <= 3'b000;
            addr_q          <= '0;
            wdata_q         <= '0;
            resp_valid      <= 1'b0;
            resp_data       <= '0;
            resp_fault      <= 1'b0;
            resp_misaligned <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (req_valid) begin
                        load_q   <= req_load;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        resp_data <= '0;
                        // Illegal encodings take priority over alignment; both bypass memory
                        if (!req_legal) begin
                            resp_fault      <= 1'b1;
                            resp_misaligned <= 1'b0;
                            resp_valid      <= 1'b1;
                            state           <= LSU_RESP;
                        end else if (req_misaligned) begin
                            resp_fault      <= 1'b0;
                            resp_misaligned <= 1'b1;
                            resp_valid      <= 1'b1;
                            state           <= LSU_RESP;
                        end else begin
                            state <= LSU_ACCESS;
                        end
                    end
                end
                LSU_ACCESS: begin
                    resp_fault      <= mem_fault;
                    resp_misaligned <= 1'b0;
                    resp_data       <= (load_q && !mem_fault) ?
                                       XLEN'(load_extend(funct3_q, 32'(mem_rdata))) : '0;
                    resp_valid      <= 1'b1;
                    state           <= LSU_RESP;
                end
                LSU_RESP: begin
                    if (resp_ready) begin
                        resp_valid      <= 1'b0;
                        resp_data       <= '0;
                        resp_fault      <= 1'b0;
                        resp_misaligned <= 1'b0;
                        state           <= LSU_IDLE;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

    // Enables are gated by reset so an interrupted store never commits
    always_comb begin
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_width    = 3'b000;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        if (state == LSU_ACCESS) begin
            mem_addr     = addr_q;
            mem_wdata    = wdata_q;
            mem_width    = funct3_q & 3'b011;
            mem_read_en  = load_q && !reset;
            mem_write_en = !load_q && !reset;
        end
    end

endmodule
